// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared state type, glyph geometry and BCD helper for the score display
package score_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } conv_state_e;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;
   localparam int BCD_W   = 4;

   // Double-dabble correction: a nibble of 5 or more would overflow a decimal digit once doubled.
   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
   import score_pkg::*;
#(
   parameter int SCORE_W    = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          start,
   input  logic [SCORE_W-1:0]            score,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_W*NUM_DIGITS-1:0]   bcd
);

   localparam int BCD_BITS = BCD_W * NUM_DIGITS;
   localparam int CNT_W    = $clog2(SCORE_W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SCORE_W - 1);

   conv_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SCORE_W-1:0]    bin_q, bin_d;
   logic [BCD_BITS-1:0]   bcd_q, bcd_d;
   logic [BCD_BITS-1:0]   adj;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      adj     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         adj[i*BCD_W +: BCD_W] = dabble(bcd_q[i*BCD_W +: BCD_W]);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CONV;
               cnt_d   = '0;
               bin_d   = score;
               bcd_d   = '0;
            end
         end
         CONV: begin
            // Carries out of the top digit are dropped, leaving the value modulo 10^NUM_DIGITS.
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy = (state_q == CONV) || (state_q == DONE);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - refreshes a decimal score per frame and renders it through a font ROM
module score_display
   import score_pkg::*;
#(
   parameter int SCORE_W    = 16,
   parameter int NUM_DIGITS = 5,
   parameter int X0         = 16,
   parameter int Y0         = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_clk,
   input  logic [SCORE_W-1:0]   score,
   input  logic [9:0]           DrawX,
   input  logic [9:0]           DrawY,
   output logic [10:0]          font_addr,
   input  logic [7:0]           font_data,
   output logic                 score_on,
   output logic                 busy
);

   localparam int BCD_BITS = BCD_W * NUM_DIGITS;

   logic                 frame_q, frame_d;
   logic                 start;
   logic                 conv_done;
   logic [BCD_BITS-1:0]  conv_bcd;
   logic [BCD_BITS-1:0]  disp_q, disp_d;
   logic                 in_box_q, in_box_d;
   logic                 blank_q, blank_d;
   logic [2:0]           col_q, col_d;
   logic [10:0]          font_addr_q, font_addr_d;
   logic                 score_on_q, score_on_d;
   logic [31:0]          dx, dy;
   logic                 in_box;
   logic [BCD_W-1:0]     digit;
   logic                 blank_sel;
   logic                 lead_zero;

   assign start = frame_clk & ~frame_q;

   bin2bcd_seq #(
      .SCORE_W    (SCORE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .Clk   (Clk),
      .Reset (Reset),
      .start (start),
      .score (score),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      frame_d   = frame_clk;
      disp_d    = conv_done ? conv_bcd : disp_q;
      dx        = 32'(DrawX) - 32'(X0);
      dy        = 32'(DrawY) - 32'(Y0);
      in_box    = (32'(DrawX) >= 32'(X0)) && (dx < 32'(GLYPH_W * NUM_DIGITS)) &&
                  (32'(DrawY) >= 32'(Y0)) && (dy < 32'(GLYPH_H));
      digit     = '0;
      blank_sel = 1'b0;
      lead_zero = 1'b1;
      // Walk from the most significant digit; glyph index 0 is the leftmost on screen.
      for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
         lead_zero = lead_zero && (disp_q[p*BCD_W +: BCD_W] == '0);
         if ((dx >> 3) == 32'(NUM_DIGITS - 1 - p)) begin
            digit     = disp_q[p*BCD_W +: BCD_W];
            blank_sel = (digit > 4'd9) || (lead_zero && (p != 0));
         end
      end
      in_box_d    = in_box;
      blank_d     = blank_sel;
      col_d       = dx[2:0];
      font_addr_d = in_box ? {3'b000, digit, dy[3:0]} : 11'd0;
      score_on_d  = in_box_q & ~blank_q & font_data[3'd7 - col_q];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_q     <= 1'b0;
         disp_q      <= '0;
         in_box_q    <= 1'b0;
         blank_q     <= 1'b0;
         col_q       <= '0;
         font_addr_q <= '0;
         score_on_q  <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         disp_q      <= disp_d;
         in_box_q    <= in_box_d;
         blank_q     <= blank_d;
         col_q       <= col_d;
         font_addr_q <= font_addr_d;
         score_on_q  <= score_on_d;
      end
   end

   assign font_addr = font_addr_q;
   assign score_on  = score_on_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - randomized and directed checks of score_display against a decimal model
module tb_score_display;

   localparam int SW = 16;
   localparam int ND = 5;
   localparam int X0 = 16;
   localparam int Y0 = 16;

   logic         Clk;
   logic         Reset;
   logic         frame_clk;
   logic [SW-1:0] score;
   logic [9:0]   DrawX;
   logic [9:0]   DrawY;
   logic [10:0]  font_addr;
   logic [7:0]   font_data;
   logic         score_on;
   logic         busy;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   score_display #(
      .SCORE_W    (SW),
      .NUM_DIGITS (ND),
      .X0         (X0),
      .Y0         (Y0)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .score     (score),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .font_addr (font_addr),
      .font_data (font_data),
      .score_on  (score_on),
      .busy      (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [7:0] rom(input int a);
      if (a == 34) return 8'h7C;
      return 8'((a * 37 + 11) ^ (a >> 3)) | 8'h18;
   endfunction

   function automatic int pow10(input int p);
      int r = 1;
      for (int i = 0; i < p; i++) r = r * 10;
      return r;
   endfunction

   assign font_data = rom(int'(font_addr));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: decimal value on display, conversion as a busy countdown.
   int m_disp, m_latched, m_left;
   bit m_frame_q;
   bit m_in1, m_blank1, m_on;
   int m_addr1, m_col1;

   always @(posedge Clk) begin
      int x, y, pos, dig;
      bit rise;
      logic [7:0] g;
      if (Reset) begin
         m_disp = 0; m_latched = 0; m_left = 0; m_frame_q = 0;
         m_in1 = 0; m_blank1 = 0; m_on = 0; m_addr1 = 0; m_col1 = 0;
      end else begin
         g    = rom(m_addr1);
         m_on = m_in1 && !m_blank1 && g[7 - m_col1];
         x = int'(DrawX);
         y = int'(DrawY);
         m_in1 = (x >= X0) && (x < X0 + 8 * ND) && (y >= Y0) && (y < Y0 + 16);
         if (m_in1) begin
            pos      = ND - 1 - (x - X0) / 8;
            dig      = (m_disp / pow10(pos)) % 10;
            m_blank1 = (pos > 0) && (m_disp < pow10(pos));
            m_addr1  = dig * 16 + (y - Y0);
            m_col1   = (x - X0) % 8;
         end else begin
            m_blank1 = 0;
            m_addr1  = 0;
            m_col1   = 0;
         end
         rise      = frame_clk && !m_frame_q;
         m_frame_q = frame_clk;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_disp = m_latched % pow10(ND);
         end else if (rise) begin
            m_latched = int'(score);
            m_left    = SW + 1;
         end
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("model_busy", int'(busy), int'(m_left > 0));
         chk("model_font_addr", int'(font_addr), m_addr1);
         chk("model_score_on", int'(score_on), int'(m_on));
      end
   end

   task automatic conv(input int s, output int nbusy);
      frame_clk = 1'b0;
      @(negedge Clk);
      score     = SW'(s);
      frame_clk = 1'b1;
      nbusy     = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (busy) nbusy++;
      end
      frame_clk = 1'b0;
   endtask

   initial begin
      int n;
      int exp_d[5];
      Reset = 1'b1; frame_clk = 1'b1; score = 16'd42; DrawX = '0; DrawY = '0;
      @(negedge Clk);
      chk_en = 1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_font_addr", int'(font_addr), 0);
      chk("reset_score_on", int'(score_on), 0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("edge_after_reset_busy", int'(busy), 1);
      repeat (20) @(negedge Clk);
      frame_clk = 1'b0;

      conv(12345, n);
      chk("busy_cycles_12345", n, 17);
      DrawX = 10'(X0 + 9); DrawY = 10'(Y0 + 2);
      @(negedge Clk);
      chk("font_addr_12345", int'(font_addr), 34);
      @(negedge Clk);
      chk("score_on_12345", int'(score_on), 1);

      conv(7, n);
      DrawX = 10'(X0); DrawY = 10'(Y0 + 4);
      @(negedge Clk);
      DrawX = 10'(X0 + 3);
      @(negedge Clk);
      chk("blank_7_col0", int'(score_on), 0);
      DrawX = 10'(X0 + 33);
      @(negedge Clk);
      chk("blank_7_col3", int'(score_on), 0);
      chk("font_addr_7", int'(font_addr), 116);

      conv(65535, n);
      exp_d = '{6, 5, 5, 3, 5};
      for (int i = 0; i < ND; i++) begin
         DrawX = 10'(X0 + 8 * i + 3); DrawY = 10'(Y0);
         @(negedge Clk);
         chk($sformatf("font_addr_65535_d%0d", i), int'(font_addr), exp_d[i] * 16);
      end

      conv(0, n);
      for (int i = 0; i < ND; i++) begin
         DrawX = 10'(X0 + 8 * i + 3); DrawY = 10'(Y0);
         @(negedge Clk);
         @(negedge Clk);
         chk($sformatf("zero_glyph_d%0d", i), int'(score_on), (i == ND - 1) ? 1 : 0);
      end

      frame_clk = 1'b0;
      @(negedge Clk);
      score = 16'd31415; frame_clk = 1'b1; n = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge Clk);
         if (busy) n++;
         if (i == 3) frame_clk = 1'b0;
         if (i == 5) frame_clk = 1'b1;
      end
      chk("busy_cycles_reedge", n, 17);
      frame_clk = 1'b0;

      conv(54321, n);
      DrawX = 10'(X0 + 3); DrawY = 10'(Y0 + 5);
      @(negedge Clk);
      score = 16'd11111; frame_clk = 1'b1; n = 0;
      for (int i = 0; i < 20 && n < 9; i++) begin
         @(negedge Clk);
         if (busy) n++;
      end
      chk("reached_conv_cycle8", n, 9);
      Reset = 1'b1; frame_clk = 1'b0;
      @(negedge Clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_score_on", int'(score_on), 0);
      Reset = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("abort_font_addr", int'(font_addr), 5);
      repeat (30) @(negedge Clk);
      chk("abort_no_restart", int'(busy), 0);
      chk("abort_digits_stay", int'(font_addr), 5);
      chk("abort_blank", int'(score_on), 0);

      for (int c = 0; c < 4000; c++) begin
         @(negedge Clk);
         Reset = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 11) == 0) frame_clk = ~frame_clk;
         case ($urandom_range(0, 3))
            0:       score = '0;
            1:       score = '1;
            2:       score = SW'($urandom_range(0, 99));
            default: score = SW'($urandom);
         endcase
         DrawX = 10'($urandom_range(X0 - 4, X0 + 8 * ND + 4));
         DrawY = 10'($urandom_range(Y0 - 2, Y0 + 17));
      end
      @(negedge Clk);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCORE_W, default 16, width of the binary score input.
REQ-002 Parameter NUM_DIGITS, default 5, number of decimal digits rendered.
REQ-003 Parameter X0, default 16, left pixel column of the score field.
REQ-004 Parameter Y0, default 16, top pixel row of the score field.
REQ-005 Clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_clk  in  1  frame strobe; its rising edge requests a score refresh.
REQ-008 score  in  SCORE_W  unsigned binary score, sampled on refresh.
REQ-009 DrawX  in  10  current pixel column.
REQ-010 DrawY  in  10  current pixel row.
REQ-011 font_addr  out  11  glyph-row address to the combinational font ROM: digit*16 + row.
REQ-012 font_data  in  8  ROM row bits; bit 7 is the leftmost pixel.
REQ-013 score_on  out  1  current pixel belongs to a lit score glyph.
REQ-014 busy  out  1  a BCD conversion is in progress.

Function
REQ-015 Rising edge of frame_clk is detected against a registered copy; in IDLE, the edge captures score and enters CONV on the next cycle.
REQ-016 CONV runs exactly SCORE_W iterations of shift-add-3 (each BCD nibble >=5 gets +3, then the whole register shifts left 1), one iteration per cycle, with a 0..SCORE_W-1 counter.
REQ-017 After the last iteration the FSM enters DONE for one cycle, loads all NUM_DIGITS digits into the display register atomically, then returns to IDLE.
REQ-018 busy is high in CONV and DONE only: SCORE_W+1 cycles per conversion.
REQ-019 frame_clk edges outside IDLE are ignored (not queued); the display register changes only in DONE.
REQ-020 Pixel stage 1 (registered): in_box = X0<=DrawX<X0+8*NUM_DIGITS and Y0<=DrawY<Y0+16; idx=(DrawX-X0)>>3, leftmost idx = most significant digit; row=DrawY-Y0; col=(DrawX-X0)[2:0].
REQ-021 font_addr = disp_digit[idx]*16 + row, registered in stage 1; 0 when not in_box.
REQ-022 Stage 2 (registered): score_on = in_box_q & ~blank_q & font_data[7-col_q]; latency from DrawX/DrawY to score_on is 2 cycles.
REQ-023 Leading-zero blanking: digits left of the first nonzero digit are blank; the units digit is never blanked (score 0 shows "0").
REQ-024 A display digit >9 (unreachable) is treated as blank.
REQ-025 Score values >= 10^NUM_DIGITS are out of contract; only the low NUM_DIGITS BCD digits are shown.

Reset
REQ-026 Reset gives: FSM IDLE, counter 0, edge register 0, all display digits 0, font_addr 0, score_on 0, busy 0, pipeline flags 0.
REQ-027 Reset mid-conversion aborts it; the partial result is discarded and the display reads "0".
REQ-028 If frame_clk is high on the first cycle after reset, that counts as a rising edge.

Structure
REQ-029 Package score_pkg holds the state enum (IDLE, CONV, DONE), GLYPH_W=8, GLYPH_H=16 and the BCD nibble width 4.
REQ-030 The sequential converter is sub-module bin2bcd_seq (start/score in, busy/done/bcd out); the pixel pipeline and blanking stay in score_display.

Verification
REQ-031 score=12345, one frame_clk edge -> busy high exactly 17 cycles; digits become 1,2,3,4,5 on the DONE cycle.
REQ-032 After 12345 is loaded, DrawX=X0+9, DrawY=Y0+2 -> font_addr=34 one cycle later; with font_data=8'b01111100, score_on=1 at two cycles.
REQ-033 score=7 -> DrawX=X0, DrawY=Y0+4 gives score_on=0 (blanked); DrawX=X0+33, DrawY=Y0+4 gives font_addr=116.
REQ-034 score=65535 -> digits 6,5,5,3,5; score=0 -> only the units glyph is lit.
REQ-035 A second frame_clk edge at CONV cycle 5 is ignored; busy stays exactly 17 cycles and no second conversion starts.
REQ-036 Reset asserted at CONV cycle 8 -> busy=0 and score_on=0 next cycle; the display shows "0" and the old digits do not return.
